// File: rtl/fifo_stream_drain_if.sv
// fifo_stream_drain_if: FIFO read port plus valid/ready output stream bundle
interface fifo_stream_drain_if #(parameter int DATA_WIDTH = 32);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_cs;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  modport master (input fifo_empty, fifo_data, m_ready, output fifo_cs, fifo_rd_en, m_valid, m_data);
  modport slave (output fifo_empty, fifo_data, m_ready, input fifo_cs, fifo_rd_en, m_valid, m_data);
endinterface

// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain: pops a registered-latency FIFO into a 2-entry skid buffer feeding a valid/ready stream
// Optional word counter (word_cnt, cnt_clr) enabled by DRAIN_WORD_CNT_EN.
module fifo_stream_drain #(
  parameter int DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  fifo_stream_drain_if.master bus,
  output logic [1:0] occ
`ifdef DRAIN_WORD_CNT_EN
  ,
  input  logic        cnt_clr,
  output logic [15:0] word_cnt
`endif
);
  logic                  inflight;
  logic                  head;
  logic                  pop;
  logic                  issue;
  logic [2:0]            lvl;
  logic [DATA_WIDTH-1:0] ent [2];
  assign pop = bus.m_valid & bus.m_ready;
  // occupancy after this edge; an in-flight word always has a reserved slot
  assign lvl = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign issue = rst & en & ~bus.fifo_empty & (lvl < 3'd2);
  assign bus.fifo_rd_en = issue;
  assign bus.fifo_cs = issue;
  assign bus.m_valid = occ != 2'd0;
  assign bus.m_data = ent[head];
  always_ff @(posedge clk)
    if (!rst) begin
      occ <= 2'd0;
      inflight <= 1'b0;
      head <= 1'b0;
      ent[0] <= '0;
      ent[1] <= '0;
    end else begin
      occ <= lvl[1:0];
      inflight <= issue;
      if (pop) head <= ~head;
      if (inflight) ent[head ^ occ[0]] <= bus.fifo_data;
    end
  assert property (@(posedge clk) disable iff (!rst) lvl <= 3'd2);
`ifdef DRAIN_WORD_CNT_EN
  always_ff @(posedge clk)
    word_cnt <= (!rst || cnt_clr) ? 16'd0 : word_cnt + {15'd0, pop};
`endif
endmodule
